seg7_scan_decoder: RTL and testbench

Receive-side counterpart of the multiplexed 7-segment display driver. Samples the 8-digit active-low anode/segment scan lines and decodes each stable digit back to a hex nibble. Reassembles two 16-bit values from a complete scan frame. Used as an on-chip loopback checker for the counter display path and as a scoreboard source in simulation.

---
 rtl/seg7_scan_decoder.sv | 164 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Loopback decoder for an 8-digit multiplexed active-low 7-segment scan.
// Samples each stable digit, decodes it to hex and reassembles two 16-bit values per frame.
`timescale 1ns/1ps
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk_100MHz_i,
    input  logic        rst_i,
    input  logic [7:0]  an_i,
    input  logic [6:0]  seg_i,
    output logic [15:0] val_1_o,
    output logic [15:0] val_2_o,
    output logic        frame_valid_o,
    output logic        seg_err_o,
    output logic [7:0]  err_cnt_o,
    output logic        stale_o
);

    localparam int              TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [TO_W-1:0] TO_MAX     = TO_W'(TIMEOUT_CYCLES);

    // Returns {ok, nibble}; ok=0 for any pattern outside the hex glyph set.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b1000000: return {1'b1, 4'h0};
            7'b1111001: return {1'b1, 4'h1};
            7'b0100100: return {1'b1, 4'h2};
            7'b0110000: return {1'b1, 4'h3};
            7'b0011001: return {1'b1, 4'h4};
            7'b0010010: return {1'b1, 4'h5};
            7'b0000010: return {1'b1, 4'h6};
            7'b1111000: return {1'b1, 4'h7};
            7'b0000000: return {1'b1, 4'h8};
            7'b0010000: return {1'b1, 4'h9};
            7'b0001000: return {1'b1, 4'hA};
            7'b0000011: return {1'b1, 4'hB};
            7'b1000110: return {1'b1, 4'hC};
            7'b0100001: return {1'b1, 4'hD};
            7'b0000110: return {1'b1, 4'hE};
            7'b0001110: return {1'b1, 4'hF};
            default:    return 5'b0_0000;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0]      an_p0, an_p1;
    logic [6:0]      seg_p0, seg_p1;
    logic [7:0]      stab_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      mask;
    logic [31:0]     shadow;

    logic            pair_same;
    logic [7:0]      stab_next;
    logic            smp_vld_p1;
    logic [7:0]      an_sel;
    logic            blank;
    logic            one_hot;
    logic [2:0]      sel_idx;
    logic [7:0]      sel_bit;
    logic [4:0]      dec;
    logic            good_smp;
    logic            bad_smp;
    logic            frame_done;
    logic [31:0]     shadow_next;
    logic [TO_W-1:0] to_next;
    logic            to_hit;

    // Stage p1: stability tracking on the registered scan lines
    always_comb begin
        pair_same  = ({an_p0, seg_p0} == {an_p1, seg_p1});
        stab_next  = 8'd0;
        if (pair_same)
            stab_next = (stab_cnt == STABLE_MAX) ? stab_cnt : stab_cnt + 8'd1;
        // Fires only on the transition into saturation, so once per stable window.
        smp_vld_p1 = pair_same && (stab_cnt == STABLE_MAX - 8'd1);
    end

    always_comb begin
        an_sel  = ~an_p0;
        blank   = (an_sel == 8'd0);
        one_hot = !blank && ((an_sel & (an_sel - 8'd1)) == 8'd0);
        sel_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (an_sel[k])
                sel_idx = 3'(k);
        end
        sel_bit = 8'd1 << sel_idx;
        dec     = decode_seg(seg_p0);
    end

    always_comb begin
        good_smp    = smp_vld_p1 && one_hot && dec[4];
        bad_smp     = smp_vld_p1 && !blank && !(one_hot && dec[4]);
        frame_done  = good_smp && ((mask | sel_bit) == 8'hFF);
        shadow_next = shadow;
        if (good_smp)
            shadow_next[{sel_idx, 2'b00} +: 4] = dec[3:0];
        to_next = TO_W'(0);
        if (!good_smp)
            to_next = (to_cnt == TO_MAX) ? to_cnt : to_cnt + TO_W'(1);
        to_hit = !good_smp && (to_cnt == TO_MAX - TO_W'(1));
    end

    // Stage p0: input capture and previous-value history
    always_ff @(posedge clk_100MHz_i) begin
        if (rst_i) begin
            an_p0  <= 8'hFF;
            seg_p0 <= 7'h7F;
            an_p1  <= 8'hFF;
            seg_p1 <= 7'h7F;
        end else begin
            an_p0  <= an_i;
            seg_p0 <= seg_i;
            an_p1  <= an_p0;
            seg_p1 <= seg_p0;
        end
    end

    // Partial-frame contents need no reset: a frame is only released once all 8 bits of mask are rewritten.
    always_ff @(posedge clk_100MHz_i) begin
        if (good_smp)
            shadow <= shadow_next;
    end

    // Stage p2: frame assembly, error accounting and timeout
    always_ff @(posedge clk_100MHz_i) begin
        if (rst_i) begin
            stab_cnt      <= 8'd0;
            to_cnt        <= TO_W'(0);
            mask          <= 8'd0;
            val_1_o       <= 16'd0;
            val_2_o       <= 16'd0;
            frame_valid_o <= 1'b0;
            seg_err_o     <= 1'b0;
            err_cnt_o     <= 8'd0;
            stale_o       <= 1'b0;
        end else begin
            stab_cnt      <= stab_next;
            to_cnt        <= to_next;
            frame_valid_o <= frame_done;
            seg_err_o     <= bad_smp;
            if (bad_smp)
                err_cnt_o <= sat_inc8(err_cnt_o);
            if (frame_done || bad_smp || to_hit)
                mask <= 8'd0;
            else if (good_smp)
                mask <= mask | sel_bit;
            if (frame_done) begin
                val_1_o <= shadow_next[31:16];
                val_2_o <= shadow_next[15:0];
                stale_o <= 1'b0;
            end else if (to_hit) begin
                stale_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: directed scans push expected frames/errors,
// a monitor pops and compares whenever frame_valid_o or seg_err_o pulses.
`timescale 1ns/1ps
module tb_seg7_scan_decoder;

    localparam int STABLE  = 16;
    localparam int TIMEOUT = 1000;
    localparam int LAT     = STABLE + 2;

    logic        clk_100MHz_i = 1'b0;
    logic        rst_i;
    logic [7:0]  an_i;
    logic [6:0]  seg_i;
    logic [15:0] val_1_o;
    logic [15:0] val_2_o;
    logic        frame_valid_o;
    logic        seg_err_o;
    logic [7:0]  err_cnt_o;
    logic        stale_o;

    seg7_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_100MHz_i (clk_100MHz_i),
        .rst_i        (rst_i),
        .an_i         (an_i),
        .seg_i        (seg_i),
        .val_1_o      (val_1_o),
        .val_2_o      (val_2_o),
        .frame_valid_o(frame_valid_o),
        .seg_err_o    (seg_err_o),
        .err_cnt_o    (err_cnt_o),
        .stale_o      (stale_o)
    );

    always #5 clk_100MHz_i = ~clk_100MHz_i;

    typedef struct {
        logic [15:0] v1;
        logic [15:0] v2;
        int          cyc;
    } frame_t;

    typedef struct {
        logic [7:0] cnt;
        int         cyc;
    } err_t;

    frame_t exp_frames[$];
    err_t   exp_errs[$];
    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    int     exp_err_n = 0;
    int     last_good = 0;

    always @(posedge clk_100MHz_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Called at a negedge; holds the pair for n cycles and returns at a negedge.
    task automatic drive(input logic [7:0] an, input logic [6:0] seg, input int n);
        an_i  = an;
        seg_i = seg;
        repeat (n) @(negedge clk_100MHz_i);
    endtask

    task automatic push_err(input int at);
        err_t e;
        exp_err_n = (exp_err_n >= 255) ? 255 : exp_err_n + 1;
        e.cnt = 8'(exp_err_n);
        e.cyc = at + LAT;
        exp_errs.push_back(e);
    endtask

    // Scan digits lo..hi; fire = digit whose sample completes a frame (-1 none),
    // short_d = digit held too briefly to sample, bad_d = digit with blank segments.
    task automatic scan(input int lo, input int hi, input logic [15:0] v1, input logic [15:0] v2,
                        input int fire, input int short_d, input int bad_d);
        logic [31:0] all;
        logic [7:0]  an;
        logic [6:0]  seg;
        frame_t      f;
        all = {v1, v2};
        for (int d = lo; d <= hi; d++) begin
            an  = ~(8'd1 << d);
            seg = (d == bad_d) ? 7'h7F : enc(all[d*4 +: 4]);
            if (d == fire) begin
                f.v1 = v1; f.v2 = v2; f.cyc = cyc + LAT;
                exp_frames.push_back(f);
            end
            if (d == bad_d) push_err(cyc);
            else if (d != short_d) last_good = cyc + LAT;
            drive(an, seg, (d == short_d) ? 10 : 40);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk_100MHz_i) begin
        if (!rst_i) begin
            if (frame_valid_o) begin
                if (exp_frames.size() == 0) begin
                    check("frame_expected", 32'(exp_frames.size()), 32'd1);
                end else begin
                    frame_t f;
                    f = exp_frames.pop_front();
                    check("frame_val_1", 32'(val_1_o), 32'(f.v1));
                    check("frame_val_2", 32'(val_2_o), 32'(f.v2));
                    check("frame_cycle", 32'(cyc), 32'(f.cyc));
                    check("frame_stale_clr", 32'(stale_o), 32'd0);
                end
            end
            if (seg_err_o) begin
                if (exp_errs.size() == 0) begin
                    check("err_expected", 32'(exp_errs.size()), 32'd1);
                end else begin
                    err_t e;
                    e = exp_errs.pop_front();
                    check("err_cnt", 32'(err_cnt_o), 32'(e.cnt));
                    check("err_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_val_1"}, 32'(val_1_o), 32'd0);
        check({tag, "_val_2"}, 32'(val_2_o), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt_o), 32'd0);
        check({tag, "_frame_valid"}, 32'(frame_valid_o), 32'd0);
        check({tag, "_seg_err"}, 32'(seg_err_o), 32'd0);
        check({tag, "_stale"}, 32'(stale_o), 32'd0);
    endtask

    initial begin
        int stale_cyc;
        rst_i = 1'b1;
        an_i  = 8'hFF;
        seg_i = 7'h7F;
        repeat (3) @(negedge clk_100MHz_i);
        check_reset_state("rst");
        rst_i = 1'b0;

        // Clean scans, then a short digit 5, then the recovering scan completing at digit 5
        scan(0, 7, 16'h1234, 16'hABCD, 7, -1, -1);
        scan(0, 7, 16'h1234, 16'hABCD, 7, -1, -1);
        scan(0, 7, 16'h1234, 16'hABCD, -1, 5, -1);
        check("hold_val_1", 32'(val_1_o), 32'h1234);
        check("hold_val_2", 32'(val_2_o), 32'hABCD);
        scan(0, 7, 16'h1234, 16'hABCD, 5, -1, -1);

        // Bad segments on digit 3 discard the partial frame; mask then holds digits 4..7
        scan(0, 7, 16'h1234, 16'hABCD, -1, -1, 3);
        check("err_cnt_after_bad", 32'(err_cnt_o), 32'd1);
        scan(0, 7, 16'h1234, 16'hABCD, 3, -1, -1);

        // Blank display until timeout
        check("stale_before_blank", 32'(stale_o), 32'd0);
        an_i = 8'hFF;
        seg_i = 7'h7F;
        stale_cyc = -1;
        for (int i = 0; i < TIMEOUT + 200; i++) begin
            @(negedge clk_100MHz_i);
            if (stale_o && stale_cyc < 0) stale_cyc = cyc;
        end
        check("stale_cycle", 32'(stale_cyc), 32'(last_good + TIMEOUT));
        check("stale_high", 32'(stale_o), 32'd1);
        scan(0, 7, 16'h1234, 16'hABCD, 7, -1, -1);
        check("stale_cleared", 32'(stale_o), 32'd0);

        // Two zeros on the anodes, then saturate the error counter
        push_err(cyc);
        drive(8'b1111_0011, 7'b1000000, 40);
        for (int i = 0; i < 300; i++) begin
            push_err(cyc);
            drive(8'hFE, (i % 2 == 0) ? 7'h7F : 7'h7E, 20);
        end
        check("err_cnt_saturated", 32'(err_cnt_o), 32'd255);

        // Reset after 5 digits: partial frame lost
        scan(0, 4, 16'h5678, 16'h9EF0, -1, -1, -1);
        an_i = 8'hFF;
        seg_i = 7'h7F;
        rst_i = 1'b1;
        @(negedge clk_100MHz_i);
        check_reset_state("midrst");
        rst_i = 1'b0;
        exp_err_n = 0;
        scan(5, 7, 16'h5678, 16'h9EF0, -1, -1, -1);
        scan(0, 4, 16'h5678, 16'h9EF0, 4, -1, -1);

        repeat (50) @(negedge clk_100MHz_i);
        check("frames_drained", 32'(exp_frames.size()), 32'd0);
        check("errs_drained", 32'(exp_errs.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
